// File: rtl/trap_ctrl.sv
// Trap/mret sequencer and arbiter for the single-port machine CSR file.
// Optional timer-interrupt path is enabled by defining TRAP_CTRL_IRQ_EN.
module trap_ctrl #(
  parameter int                    DATA_LEN  = 32,
  parameter logic [DATA_LEN-1:0]   IRQ_CAUSE = 32'h80000007
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_csr_valid,
  input  logic                inst_csr_wen,
  input  logic                inst_csr_ren,
  input  logic [11:0]         inst_csr_addr,
  input  logic [DATA_LEN-1:0] inst_csr_wdata,
  output logic                inst_csr_ready,
  output logic [DATA_LEN-1:0] inst_csr_rdata,
  input  logic                exc_valid,
  input  logic [DATA_LEN-1:0] exc_cause,
  input  logic [DATA_LEN-1:0] exc_pc,
  input  logic                mret_valid,
  input  logic                irq_timer,
  input  logic [DATA_LEN-1:0] irq_pc,
  output logic                exc_ready,
  output logic                csr_wen,
  output logic                csr_ren,
  output logic [11:0]         csr_addr,
  output logic [DATA_LEN-1:0] csr_wdata,
  input  logic [DATA_LEN-1:0] csr_rdata,
  output logic                redirect_valid,
  output logic [DATA_LEN-1:0] redirect_pc,
  output logic                busy
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_EPC    = 4'd1;
  localparam logic [3:0] S_CAUSE  = 4'd2;
  localparam logic [3:0] S_ST_RD  = 4'd3;
  localparam logic [3:0] S_ST_WR  = 4'd4;
  localparam logic [3:0] S_VEC    = 4'd5;
  localparam logic [3:0] S_REDIR  = 4'd6;
  localparam logic [3:0] S_EPC_RD = 4'd7;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  logic [3:0]          state_q, state_d;
  logic [DATA_LEN-1:0] save_pc_q, save_pc_d;
  logic [DATA_LEN-1:0] save_cause_q, save_cause_d;
  logic [DATA_LEN-1:0] st_tmp_q, st_tmp_d;
  logic [DATA_LEN-1:0] target_q, target_d;
  logic                is_mret_q, is_mret_d;
  logic [DATA_LEN-1:0] st_new;

`ifdef TRAP_CTRL_IRQ_EN
  logic mie_shadow_q, mie_shadow_d;
`else
  logic unused_irq;
  assign unused_irq = ^{irq_timer, irq_pc};
`endif

  assign busy = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d        = state_q;
    save_pc_d      = save_pc_q;
    save_cause_d   = save_cause_q;
    st_tmp_d       = st_tmp_q;
    target_d       = target_q;
    is_mret_d      = is_mret_q;
`ifdef TRAP_CTRL_IRQ_EN
    mie_shadow_d   = mie_shadow_q;
`endif
    inst_csr_ready = 1'b0;
    inst_csr_rdata = '0;
    exc_ready      = 1'b0;
    csr_wen        = 1'b0;
    csr_ren        = 1'b0;
    csr_addr       = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Trap: MPIE <- MIE, MIE <- 0. Mret: MIE <- MPIE, MPIE <- 1. MPP is always M-mode.
    st_new = st_tmp_q;
    if (is_mret_q) begin
      st_new[3] = st_tmp_q[7];
      st_new[7] = 1'b1;
    end else begin
      st_new[7] = st_tmp_q[3];
      st_new[3] = 1'b0;
    end
    st_new[12:11] = 2'b11;

    case (state_q)
      S_IDLE: begin
        exc_ready = 1'b1;
        if (exc_valid) begin
          state_d      = S_EPC;
          save_pc_d    = exc_pc;
          save_cause_d = exc_cause;
          is_mret_d    = 1'b0;
        end else if (mret_valid) begin
          state_d   = S_ST_RD;
          is_mret_d = 1'b1;
        end
`ifdef TRAP_CTRL_IRQ_EN
        else if (irq_timer && mie_shadow_q) begin
          state_d      = S_EPC;
          save_pc_d    = irq_pc;
          save_cause_d = IRQ_CAUSE;
          is_mret_d    = 1'b0;
        end
`endif
        else if (inst_csr_valid) begin
          inst_csr_ready = 1'b1;
          csr_wen        = inst_csr_wen;
          csr_ren        = inst_csr_ren;
          csr_addr       = inst_csr_addr;
          csr_wdata      = inst_csr_wen ? inst_csr_wdata : '0;
          inst_csr_rdata = csr_rdata;
`ifdef TRAP_CTRL_IRQ_EN
          if (inst_csr_wen && inst_csr_addr == A_MSTATUS) mie_shadow_d = inst_csr_wdata[3];
`endif
        end
      end
      S_EPC: begin
        csr_wen   = 1'b1;
        csr_addr  = A_MEPC;
        csr_wdata = save_pc_q;
        state_d   = S_CAUSE;
      end
      S_CAUSE: begin
        csr_wen   = 1'b1;
        csr_addr  = A_MCAUSE;
        csr_wdata = save_cause_q;
        state_d   = S_ST_RD;
      end
      S_ST_RD: begin
        csr_ren  = 1'b1;
        csr_addr = A_MSTATUS;
        st_tmp_d = csr_rdata;
        state_d  = S_ST_WR;
      end
      S_ST_WR: begin
        csr_wen   = 1'b1;
        csr_addr  = A_MSTATUS;
        csr_wdata = st_new;
`ifdef TRAP_CTRL_IRQ_EN
        mie_shadow_d = st_new[3];
`endif
        state_d   = is_mret_q ? S_EPC_RD : S_VEC;
      end
      S_VEC: begin
        csr_ren  = 1'b1;
        csr_addr = A_MTVEC;
        target_d = {csr_rdata[DATA_LEN-1:2], 2'b00};
        state_d  = S_REDIR;
      end
      S_EPC_RD: begin
        csr_ren  = 1'b1;
        csr_addr = A_MEPC;
        target_d = csr_rdata;
        state_d  = S_REDIR;
      end
      S_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q      <= S_IDLE;
      save_pc_q    <= '0;
      save_cause_q <= '0;
      st_tmp_q     <= '0;
      target_q     <= '0;
      is_mret_q    <= 1'b0;
`ifdef TRAP_CTRL_IRQ_EN
      mie_shadow_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      save_pc_q    <= save_pc_d;
      save_cause_q <= save_cause_d;
      st_tmp_q     <= st_tmp_d;
      target_q     <= target_d;
      is_mret_q    <= is_mret_d;
`ifdef TRAP_CTRL_IRQ_EN
      mie_shadow_q <= mie_shadow_d;
`endif
    end
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequencer and arbiter for the single-port machine CSR file (mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342).
- Shares the CSR port between the execute stage's CSR instructions and the trap/mret sequences, and performs the multi-cycle writes these sequences require.
- Issues a one-cycle PC redirect to the fetch unit when a sequence completes.

Parameters:
DATA_LEN, 32, CSR/PC width (must be 32)
IRQ_CAUSE, 32'h80000007, mcause value written for the machine timer interrupt

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
inst_csr_valid  in  1  CSR instruction access request from the execute stage
inst_csr_wen  in  1  instruction write
inst_csr_ren  in  1  instruction read
inst_csr_addr  in  12  instruction CSR address
inst_csr_wdata  in  DATA_LEN  instruction write data
inst_csr_ready  out  1  instruction access accepted this cycle
inst_csr_rdata  out  DATA_LEN  instruction read data (valid while inst_csr_ready=1)
exc_valid  in  1  synchronous exception request; held until exc_ready
exc_cause  in  DATA_LEN  exception cause
exc_pc  in  DATA_LEN  faulting PC
mret_valid  in  1  mret request; held until exc_ready
irq_timer  in  1  level timer interrupt
irq_pc  in  DATA_LEN  PC of the next instruction, saved on interrupt
exc_ready  out  1  high in IDLE; the request is accepted when valid & ready
csr_wen  out  1  CSR file write enable
csr_ren  out  1  CSR file read enable
csr_addr  out  12  CSR file address
csr_wdata  out  DATA_LEN  CSR file write data
csr_rdata  in  DATA_LEN  CSR file read data, combinational, same cycle
redirect_valid  out  1  one-cycle PC redirect pulse
redirect_pc  out  DATA_LEN  redirect target
busy  out  1  high in every state other than IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0 except exc_ready=1; latches cleared; mie_shadow=0.
- Reset mid-sequence aborts the sequence with no redirect.
- IDLE arbitration, fixed priority, highest first:
  - exc_valid
  - mret_valid
  - irq_timer & mie_shadow (taken only when no exception or mret is pending)
  - inst_csr_valid
- In IDLE with no sequence starting, CSR instruction accesses pass through combinationally:
  - csr_* = inst_csr_*, inst_csr_rdata = csr_rdata, inst_csr_ready=1.
- inst_csr_ready=0 in every other state, and in the cycle a sequence is accepted.
- On accept, latch into save_pc and save_cause:
  - exception: exc_pc / exc_cause
  - interrupt: irq_pc / IRQ_CAUSE
- Trap sequence (accept at cycle T):
  - T+1 EPC: write mepc = save_pc.
  - T+2 CAUSE: write mcause = save_cause.
  - T+3 ST_RD: read mstatus into st_tmp.
  - T+4 ST_WR: write st_tmp with bit7(MPIE) = old bit3(MIE), bit3 = 0, bits[12:11](MPP) = 2'b11.
  - T+5 VEC: read mtvec; target = {mtvec[DATA_LEN-1:2], 2'b00} (direct mode only).
  - T+6 REDIR: redirect_valid=1, redirect_pc=target.
  - T+7 IDLE.
- Mret sequence (accept at cycle T):
  - T+1 ST_RD: read mstatus into st_tmp.
  - T+2 ST_WR: write st_tmp with bit3 = old bit7, bit7 = 1, MPP = 2'b11.
  - T+3 EPC_RD: read mepc into target.
  - T+4 REDIR: redirect_valid=1, redirect_pc=target.
  - T+5 IDLE.
- CSR port outputs: csr_ren=1 only in read states, csr_wen=1 only in write states; csr_wdata=0 when not writing.
- mie_shadow tracks mstatus.MIE. It updates on ST_WR and on any pass-through instruction write to 0x300 (takes wdata bit3).
- Requests arriving while busy are not accepted; requesters must hold valid.
- irq_timer is level-sensitive and is not latched.
- redirect_valid is exactly one cycle wide.

Optional Feature:
TRAP_CTRL_IRQ_EN
- Defined: timer-interrupt path as above.
- Undefined: irq_timer and irq_pc are ignored, no interrupt sequence exists, and mie_shadow logic may be removed. Exception, mret and pass-through behaviour are unchanged.

Test Plan:
- Reset, then pass-through: inst write 0x305 = 0x80000100, then read 0x305 -> inst_csr_ready=1 in both cycles, rdata=0x80000100, busy=0.
- Exception: mstatus=0x1808, exc_pc=0x80000040, cause=11 -> mepc=0x80000040 at T+1, mcause=11 at T+2, mstatus=0x1880 at T+4, redirect_valid only at T+6 with pc=0x80000100.
- Mret after the trap: mepc=0x80000044 (written by instruction) -> mstatus=0x1888 at T+2, redirect_pc=0x80000044 at T+4.
- Simultaneous exc_valid, mret_valid and inst_csr_valid in IDLE -> exception sequence runs, inst_csr_ready=0 until back in IDLE, mret is accepted at T+7.
- Interrupt (macro on): irq_timer=1 with mstatus.MIE=1, irq_pc=0x80000080 -> mcause=0x80000007, mepc=0x80000080; with MIE=0 -> no sequence, busy stays 0.
- rst=1 during T+3 of a trap -> next cycle state IDLE, redirect_valid never asserted, exc_ready=1.
